ext_bus_responder: RTL

//  Memory-side responder for the cpu request interface (address/read/write/byteCount/data

---
 rtl/ext_bus_responder_pkg.sv | 37 +++
 rtl/ext_bus_responder_byte_cycle.sv | 177 +++++++++++++++++
 rtl/ext_bus_responder.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/ext_bus_responder_pkg.sv
// Shared types, timing defaults and address decode for the external bus responder.
package ext_bus_responder_pkg;

    localparam int unsigned ADDR_W = 24;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned BYTE_W = 8;
    localparam int unsigned CNT_W  = 8;

    localparam int unsigned DEF_LATCH_CYCLES  = 2;
    localparam int unsigned DEF_ACCESS_CYCLES = 3;
    localparam logic [15:0] DEF_ROM_TOP       = 16'h7FFF;

    typedef enum logic [1:0] {CHIP_NONE, CHIP_ROM, CHIP_RAM} chip_e;
    typedef enum logic [1:0] {REQ_IDLE, REQ_RUN, REQ_DONE} reqState_e;
    typedef enum logic [2:0] {BC_IDLE, BC_LATCH_LO, BC_LATCH_HI, BC_ACCESS, BC_RECOVER} bcState_e;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic              isWrite;
        logic              skipHi;
        logic [BYTE_W-1:0] data;
    } byteReq_t;

    function automatic chip_e decodeChip(input logic [ADDR_W-1:0] addr, input logic [15:0] romTop);
        chip_e chip;
        if (addr[23:16] != 8'h00)     chip = CHIP_NONE;
        else if (addr[15:0] <= romTop) chip = CHIP_ROM;
        else                           chip = CHIP_RAM;
        return chip;
    endfunction

    // A byte with no device behind it, or a write aimed at ROM, produces no bus activity.
    function automatic logic isSuppressed(input chip_e chip, input logic isWrite);
        return (chip == CHIP_NONE) || (isWrite && (chip == CHIP_ROM));
    endfunction

endpackage

// File: rtl/ext_bus_responder_byte_cycle.sv
// Runs the latch / access / recover sequence for one byte on the multiplexed bus.
module ext_bus_responder_byte_cycle
    import ext_bus_responder_pkg::*;
#(
    parameter int unsigned LATCH_CYCLES  = DEF_LATCH_CYCLES,
    parameter int unsigned ACCESS_CYCLES = DEF_ACCESS_CYCLES,
    parameter logic [15:0] ROM_TOP       = DEF_ROM_TOP
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] addr,
    input  logic              isWrite,
    input  logic              skipHi,
    input  logic [BYTE_W-1:0] wdata,
    input  logic [BYTE_W-1:0] ioIn,
    output logic              done_c,
    output logic [BYTE_W-1:0] rdata,
    output logic [BYTE_W-1:0] ioOut,
    output logic              ioOe,
    output logic              addressLatch0,
    output logic              addressLatch1,
    output logic              ramChipEnable,
    output logic              ramRead,
    output logic              ramWrite,
    output logic              romChipEnable,
    output logic              romRead
);

    localparam logic [CNT_W-1:0] LATCH_LAST  = CNT_W'(LATCH_CYCLES);
    localparam logic [CNT_W-1:0] ACCESS_LAST = CNT_W'(ACCESS_CYCLES - 1);

    bcState_e          state, nextState;
    logic [CNT_W-1:0]  cnt, nextCnt;
    byteReq_t          cur, nxt;
    chip_e             curChip, nxtChip;
    logic              curSup, nxtSup;
    logic              ioOeN, latch0N, latch1N, ramCeN, ramRdN, ramWrN, romCeN, romRdN;
    logic [BYTE_W-1:0] ioOutN;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= BC_IDLE;
            cnt   <= '0;
            cur   <= '0;
        end else begin
            state <= nextState;
            cnt   <= nextCnt;
            cur   <= nxt;
        end
    end

    // Outputs are decoded from the next state so the strobes leave a register.
    always_comb begin
        nxt       = cur;
        nextState = state;
        nextCnt   = cnt;
        done_c    = 1'b0;
        ioOeN     = 1'b0;
        ioOutN    = '0;
        latch0N   = 1'b0;
        latch1N   = 1'b0;
        ramCeN    = 1'b0;
        ramRdN    = 1'b0;
        ramWrN    = 1'b0;
        romCeN    = 1'b0;
        romRdN    = 1'b0;

        if (start) begin
            nxt.addr    = addr;
            nxt.isWrite = isWrite;
            nxt.skipHi  = skipHi;
            nxt.data    = wdata;
        end
        curChip = decodeChip(cur.addr, ROM_TOP);
        curSup  = isSuppressed(curChip, cur.isWrite);
        nxtChip = decodeChip(nxt.addr, ROM_TOP);
        nxtSup  = isSuppressed(nxtChip, nxt.isWrite);

        case (state)
            BC_LATCH_LO: begin
                nextCnt = cnt + CNT_W'(1);
                if (cnt == LATCH_LAST) begin
                    nextState = cur.skipHi ? BC_ACCESS : BC_LATCH_HI;
                    nextCnt   = '0;
                end
            end
            BC_LATCH_HI: begin
                nextCnt = cnt + CNT_W'(1);
                if (cnt == LATCH_LAST) begin
                    nextState = BC_ACCESS;
                    nextCnt   = '0;
                end
            end
            BC_ACCESS: begin
                nextCnt = cnt + CNT_W'(1);
                if (curSup) begin
                    done_c    = 1'b1;
                    nextState = BC_IDLE;
                end else if (cnt == ACCESS_LAST) begin
                    nextState = BC_RECOVER;
                    nextCnt   = '0;
                end
            end
            BC_RECOVER: begin
                done_c    = 1'b1;
                nextState = BC_IDLE;
            end
            default: nextState = BC_IDLE;
        endcase

        if (start) begin
            nextState = nxtSup ? BC_ACCESS : BC_LATCH_LO;
            nextCnt   = '0;
        end

        case (nextState)
            BC_LATCH_LO: begin
                ioOeN   = 1'b1;
                ioOutN  = nxt.addr[7:0];
                latch0N = (nextCnt < LATCH_LAST);
            end
            BC_LATCH_HI: begin
                ioOeN   = 1'b1;
                ioOutN  = nxt.addr[15:8];
                latch1N = (nextCnt < LATCH_LAST);
            end
            BC_ACCESS: begin
                if (!nxtSup) begin
                    if (nxt.isWrite) begin
                        ioOeN  = 1'b1;
                        ioOutN = nxt.data;
                        ramCeN = 1'b1;
                        ramWrN = 1'b1;
                    end else if (nxtChip == CHIP_ROM) begin
                        romCeN = 1'b1;
                        romRdN = 1'b1;
                    end else begin
                        ramCeN = 1'b1;
                        ramRdN = 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ioOe          <= 1'b0;
            ioOut         <= '0;
            addressLatch0 <= 1'b0;
            addressLatch1 <= 1'b0;
            ramChipEnable <= 1'b0;
            ramRead       <= 1'b0;
            ramWrite      <= 1'b0;
            romChipEnable <= 1'b0;
            romRead       <= 1'b0;
            rdata         <= '0;
        end else begin
            ioOe          <= ioOeN;
            ioOut         <= ioOutN;
            addressLatch0 <= latch0N;
            addressLatch1 <= latch1N;
            ramChipEnable <= ramCeN;
            ramRead       <= ramRdN;
            ramWrite      <= ramWrN;
            romChipEnable <= romCeN;
            romRead       <= romRdN;
            if (start)
                rdata <= '0;
            else if (state == BC_ACCESS && !curSup && !cur.isWrite && cnt == ACCESS_LAST)
                rdata <= ioIn;
        end
    end

endmodule

// File: rtl/ext_bus_responder.sv
// Memory-side responder: accepts 1-4 byte cpu requests and sequences byte cycles on the external bus.
module ext_bus_responder
    import ext_bus_responder_pkg::*;
#(
    parameter int unsigned LATCH_CYCLES  = DEF_LATCH_CYCLES,
    parameter int unsigned ACCESS_CYCLES = DEF_ACCESS_CYCLES,
    parameter logic [15:0] ROM_TOP       = DEF_ROM_TOP
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] address,
    input  logic              read,
    input  logic              write,
    input  logic [DATA_W-1:0] dataIn,
    input  logic [1:0]        byteCount,
    input  logic              dataInReady,
    output logic [DATA_W-1:0] dataOut,
    output logic              dataOutReady,
    output logic              busy,
    output logic [BYTE_W-1:0] ioOut,
    input  logic [BYTE_W-1:0] ioIn,
    output logic              ioOe,
    output logic              addressLatch0,
    output logic              addressLatch1,
    output logic              ramChipEnable,
    output logic              ramRead,
    output logic              ramWrite,
    output logic              romChipEnable,
    output logic              romRead
);

    reqState_e         state, nextState;
    logic [ADDR_W-1:0] curAddr, nextAddr_c, startAddr_c;
    logic [1:0]        count, idx;
    logic              isWriteR;
    logic [23:0]       wdataR;
    logic [DATA_W-1:0] rdataAcc, assembled_c;
    logic [BYTE_W-1:0] startData_c, rdataByte;
    logic              accept_c, lastByte_c, byteDone_c, start_c, startWrite_c, skipHi_c;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= REQ_IDLE;
        else     state <= nextState;
    end

    // Request acceptance, next-byte launch and page-reuse decision.
    always_comb begin
        nextState    = state;
        start_c      = 1'b0;
        startAddr_c  = address;
        startWrite_c = !read;
        startData_c  = dataIn[7:0];
        skipHi_c     = 1'b0;
        accept_c     = (state == REQ_IDLE) && (read || (write && dataInReady));
        lastByte_c   = (idx == count);
        nextAddr_c   = curAddr + ADDR_W'(1);
        assembled_c  = rdataAcc | (DATA_W'(rdataByte) << {idx, 3'b000});

        case (state)
            REQ_IDLE: begin
                if (accept_c) begin
                    start_c   = 1'b1;
                    nextState = REQ_RUN;
                end
            end
            REQ_RUN: begin
                if (byteDone_c) begin
                    if (lastByte_c) begin
                        nextState = REQ_DONE;
                    end else begin
                        start_c      = 1'b1;
                        startAddr_c  = nextAddr_c;
                        startWrite_c = isWriteR;
                        startData_c  = wdataR[7:0];
                        skipHi_c     = !isSuppressed(decodeChip(curAddr, ROM_TOP), isWriteR)
                                       && (nextAddr_c[15:8] == curAddr[15:8]);
                    end
                end
            end
            default: nextState = REQ_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            curAddr      <= '0;
            count        <= '0;
            idx          <= '0;
            isWriteR     <= 1'b0;
            wdataR       <= '0;
            rdataAcc     <= '0;
            dataOut      <= '0;
            dataOutReady <= 1'b0;
            busy         <= 1'b0;
        end else begin
            dataOutReady <= (nextState == REQ_DONE);
            busy         <= (nextState != REQ_IDLE);
            if (accept_c) begin
                curAddr  <= address;
                count    <= byteCount;
                idx      <= '0;
                isWriteR <= !read;
                wdataR   <= dataIn[31:8];
                rdataAcc <= '0;
            end else if (state == REQ_RUN && byteDone_c) begin
                if (!lastByte_c) begin
                    curAddr  <= nextAddr_c;
                    idx      <= idx + 2'd1;
                    wdataR   <= wdataR >> 8;
                    rdataAcc <= assembled_c;
                end else if (!isWriteR) begin
                    dataOut <= assembled_c;
                end
            end
        end
    end

    ext_bus_responder_byte_cycle #(
        .LATCH_CYCLES (LATCH_CYCLES),
        .ACCESS_CYCLES(ACCESS_CYCLES),
        .ROM_TOP      (ROM_TOP)
    ) u_byteCycle (
        .clk          (clk),
        .rst          (rst),
        .start        (start_c),
        .addr         (startAddr_c),
        .isWrite      (startWrite_c),
        .skipHi       (skipHi_c),
        .wdata        (startData_c),
        .ioIn         (ioIn),
        .done_c       (byteDone_c),
        .rdata        (rdataByte),
        .ioOut        (ioOut),
        .ioOe         (ioOe),
        .addressLatch0(addressLatch0),
        .addressLatch1(addressLatch1),
        .ramChipEnable(ramChipEnable),
        .ramRead      (ramRead),
        .ramWrite     (ramWrite),
        .romChipEnable(romChipEnable),
        .romRead      (romRead)
    );

endmodule
